pipeline_trace_buffer: RTL and testbench



---
 rtl/pipeline_trace_buffer.sv | 159 +++++++++++++++
 tb/tb_pipeline_trace_buffer.sv | 214 +++++++++++++++++++++
 2 files changed

// File: rtl/pipeline_trace_buffer.sv
// Circular trace buffer that freezes a pre/post window of samples around an address-match or external trigger.
// Capture is one sample per valid cycle; read data appears one cycle after an accepted rd_en.
// No stall on the write side (samples arriving outside capture are dropped); reads advance one entry per rd_en cycle.
module pipeline_trace_buffer #(
  parameter int SAMPLE_W = 36,
  parameter int DEPTH    = 16,
  parameter int ADDR_W   = 8,
  parameter int ADDR_LSB = 28,
  parameter int CNT_W    = $clog2(DEPTH) + 1
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                sample_valid,
  input  logic [SAMPLE_W-1:0] sample_in,
  input  logic                arm,
  input  logic                ext_trig,
  input  logic                addr_trig_en,
  input  logic [ADDR_W-1:0]   trig_addr,
  input  logic [CNT_W-1:0]    post_count,
  input  logic                rd_en,
  output logic [SAMPLE_W-1:0] rd_data,
  output logic                rd_valid,
  output logic                rd_last,
  output logic                armed,
  output logic                triggered,
  output logic                done,
  output logic [CNT_W-1:0]    fill,
  output logic [CNT_W-1:0]    trig_index
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam logic [CNT_W-1:0] DEPTH_C  = CNT_W'(DEPTH);
  localparam logic [CNT_W-1:0] MAX_POST = CNT_W'(DEPTH - 1);

  typedef enum logic [1:0] {S_IDLE, S_ARMED, S_TRIG, S_DONE} state_t;

  state_t              state, state_nxt;
  logic [SAMPLE_W-1:0] mem [DEPTH];
  logic [PTR_W-1:0]    wr_ptr, rd_ptr, wr_ptr_nxt;
  logic [CNT_W-1:0]    post_cnt, post_eff_q, rd_cnt;
  logic [CNT_W-1:0]    post_eff, fill_nxt, freeze_post;
  logic                triggered_q;
  logic                wr_en, hit, freeze, rd_fire;

  // Next-state decode plus write/trigger/read strobes; arm overrides every other event.
  always_comb begin
    state_nxt   = state;
    wr_en       = 1'b0;
    hit         = 1'b0;
    freeze      = 1'b0;
    freeze_post = '0;
    rd_fire     = 1'b0;
    // Clamp so the trigger sample can never be overwritten by its own post window.
    post_eff    = (post_count > MAX_POST) ? MAX_POST : post_count;
    wr_ptr_nxt  = wr_ptr + PTR_W'(1);
    fill_nxt    = (fill == DEPTH_C) ? fill : fill + CNT_W'(1);
    if (arm) begin
      state_nxt = S_ARMED;
    end else begin
      case (state)
        S_ARMED: begin
          if (sample_valid) begin
            wr_en = 1'b1;
            hit   = ext_trig | (addr_trig_en && (sample_in[ADDR_LSB +: ADDR_W] == trig_addr));
            if (hit) begin
              if (post_eff == '0) begin
                state_nxt = S_DONE;
                freeze    = 1'b1;
              end else begin
                state_nxt = S_TRIG;
              end
            end
          end
        end
        S_TRIG: begin
          if (sample_valid) begin
            wr_en = 1'b1;
            if (post_cnt == CNT_W'(1)) begin
              state_nxt   = S_DONE;
              freeze      = 1'b1;
              freeze_post = post_eff_q;
            end
          end
        end
        S_DONE: rd_fire = rd_en && (rd_cnt != fill);
        default: ;
      endcase
    end
  end

  // Control state: pointers, fill, post-trigger countdown and frozen readout origin.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state       <= S_IDLE;
      wr_ptr      <= '0;
      rd_ptr      <= '0;
      fill        <= '0;
      post_cnt    <= '0;
      post_eff_q  <= '0;
      rd_cnt      <= '0;
      trig_index  <= '0;
      triggered_q <= 1'b0;
    end else begin
      state <= state_nxt;
      if (arm) begin
        wr_ptr      <= '0;
        rd_ptr      <= '0;
        fill        <= '0;
        rd_cnt      <= '0;
        post_cnt    <= '0;
        triggered_q <= 1'b0;
      end else begin
        if (wr_en) begin
          wr_ptr <= wr_ptr_nxt;
          fill   <= fill_nxt;
        end
        if (hit) begin
          triggered_q <= 1'b1;
          post_cnt    <= post_eff;
          post_eff_q  <= post_eff;
        end else if (wr_en && state == S_TRIG) begin
          post_cnt <= post_cnt - CNT_W'(1);
        end
        // Once full, the oldest surviving entry sits at the next write slot.
        if (freeze) begin
          trig_index <= fill_nxt - CNT_W'(1) - freeze_post;
          rd_ptr     <= (fill_nxt == DEPTH_C) ? wr_ptr_nxt : '0;
        end
        if (rd_fire) begin
          rd_ptr <= rd_ptr + PTR_W'(1);
          rd_cnt <= rd_cnt + CNT_W'(1);
        end
      end
    end
  end

  // Sample storage; contents are deliberately left unreset.
  always_ff @(posedge clk) begin
    if (wr_en) mem[wr_ptr] <= sample_in;
  end

  // Registered read port; rd_data holds its last value when no read is accepted.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      rd_data  <= '0;
      rd_valid <= 1'b0;
      rd_last  <= 1'b0;
    end else begin
      rd_valid <= rd_fire;
      rd_last  <= rd_fire && ((rd_cnt + CNT_W'(1)) == fill);
      if (rd_fire) rd_data <= mem[rd_ptr];
    end
  end

  assign armed     = (state == S_ARMED) || (state == S_TRIG);
  assign done      = (state == S_DONE);
  assign triggered = triggered_q;

endmodule

// File: tb/tb_pipeline_trace_buffer.sv
module tb_pipeline_trace_buffer;

  localparam int SAMPLE_W = 36;
  localparam int DEPTH    = 16;
  localparam int CNT_W    = 5;

  logic                clk = 1'b0;
  logic                reset = 1'b0;
  logic                sample_valid = 1'b0;
  logic [SAMPLE_W-1:0] sample_in = '0;
  logic                arm = 1'b0;
  logic                ext_trig = 1'b0;
  logic                addr_trig_en = 1'b0;
  logic [7:0]          trig_addr = '0;
  logic [CNT_W-1:0]    post_count = '0;
  logic                rd_en = 1'b0;
  logic [SAMPLE_W-1:0] rd_data;
  logic                rd_valid, rd_last, armed, triggered, done;
  logic [CNT_W-1:0]    fill, trig_index;

  int errors = 0;
  int checks = 0;
  logic [SAMPLE_W:0] exp_q[$];

  pipeline_trace_buffer #(.SAMPLE_W(SAMPLE_W), .DEPTH(DEPTH), .ADDR_W(8), .ADDR_LSB(28), .CNT_W(CNT_W)) dut (
    .clk(clk), .reset(reset), .sample_valid(sample_valid), .sample_in(sample_in),
    .arm(arm), .ext_trig(ext_trig), .addr_trig_en(addr_trig_en), .trig_addr(trig_addr),
    .post_count(post_count), .rd_en(rd_en), .rd_data(rd_data), .rd_valid(rd_valid),
    .rd_last(rd_last), .armed(armed), .triggered(triggered), .done(done),
    .fill(fill), .trig_index(trig_index)
  );

  always #5 clk = ~clk;

  // Sample image for a given address: {addr, ins, ans_wb}
  function automatic logic [SAMPLE_W-1:0] smp(input logic [7:0] a);
    return {a, 12'hABC, a, ~a};
  endfunction

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic feed(input logic [7:0] a, input logic et);
    sample_valid = 1'b1;
    sample_in    = smp(a);
    ext_trig     = et;
    tick();
    sample_valid = 1'b0;
    ext_trig     = 1'b0;
  endtask

  task automatic do_arm();
    arm = 1'b1;
    tick();
    arm = 1'b0;
  endtask

  task automatic expect_entry(input logic [7:0] a, input logic last);
    exp_q.push_back({last, smp(a)});
  endtask

  task automatic do_reads(input int n);
    rd_en = 1'b1;
    repeat (n) tick();
    rd_en = 1'b0;
    tick();
    tick();
    check("read_drain", 64'(exp_q.size()), 64'd0);
  endtask

  // Monitor: every presented read beat must match the head of the scoreboard.
  always @(negedge clk) begin
    if (rd_valid === 1'b1) begin
      checks++;
      if (exp_q.size() == 0) begin
        errors++;
        $display("FAIL unexpected_read: got data %0h last %0b expected no read", rd_data, rd_last);
      end else begin
        logic [SAMPLE_W:0] e;
        e = exp_q.pop_front();
        if ({rd_last, rd_data} !== e) begin
          errors++;
          $display("FAIL read_beat: got last %0b data %0h expected last %0b data %0h",
                   rd_last, rd_data, e[SAMPLE_W], e[SAMPLE_W-1:0]);
        end
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "timeout");
  end

  initial begin
    // Reset state
    #2;
    check("reset_outputs", {rd_data, rd_valid, rd_last, armed, triggered, done, fill, trig_index}, '0);
    #21 reset = 1'b1;
    tick();
    rd_en = 1'b1;
    repeat (3) tick();
    rd_en = 1'b0;
    tick();
    check("no_done_without_arm", done, 1'b0);

    // Reset mid-capture
    addr_trig_en = 1'b0;
    do_arm();
    feed(8'd1, 1'b0);
    feed(8'd2, 1'b0);
    check("pre_reset_fill", fill, 5'd2);
    #2 reset = 1'b0;
    #1;
    check("mid_reset_state", {armed, triggered, done, fill}, '0);
    #3 reset = 1'b1;
    tick();
    feed(8'd3, 1'b1);
    check("no_capture_after_reset", {armed, triggered, done, fill}, '0);

    // Pre/post window
    addr_trig_en = 1'b1;
    trig_addr    = 8'd5;
    post_count   = 5'd3;
    do_arm();
    for (int a = 0; a <= 12; a++) begin
      feed(8'(a), 1'b0);
      if (a == 5) check("win_trig_flags", {armed, triggered}, 2'b11);
      if (a == 7) check("win_not_done", done, 1'b0);
      if (a == 8) check("win_done", done, 1'b1);
    end
    check("win_fill", fill, 5'd9);
    check("win_trig_index", trig_index, 5'd5);
    check("win_armed_off", armed, 1'b0);
    for (int a = 0; a <= 8; a++) expect_entry(8'(a), a == 8);
    do_reads(10);

    // Wrap-around
    trig_addr  = 8'd20;
    post_count = 5'd4;
    do_arm();
    for (int a = 0; a <= 30; a++) feed(8'(a), 1'b0);
    check("wrap_done", done, 1'b1);
    check("wrap_fill", fill, 5'd16);
    check("wrap_trig_index", trig_index, 5'd11);
    for (int a = 9; a <= 24; a++) expect_entry(8'(a), a == 24);
    do_reads(17);

    // Immediate freeze on external trigger
    addr_trig_en = 1'b0;
    post_count   = 5'd0;
    do_arm();
    for (int a = 0; a <= 3; a++) feed(8'(a), 1'b0);
    feed(8'd7, 1'b1);
    check("imm_done", done, 1'b1);
    check("imm_fill", fill, 5'd5);
    check("imm_trig_index", trig_index, 5'd4);
    for (int a = 0; a <= 3; a++) expect_entry(8'(a), 1'b0);
    expect_entry(8'd7, 1'b1);
    do_reads(5);

    // Priority and gaps
    sample_valid = 1'b1;
    sample_in    = smp(8'd50);
    ext_trig     = 1'b1;
    arm          = 1'b1;
    tick();
    arm          = 1'b0;
    sample_valid = 1'b0;
    check("arm_prio", {armed, triggered, fill}, {1'b1, 1'b0, 5'd0});
    ext_trig = 1'b1;
    repeat (3) tick();
    ext_trig = 1'b0;
    check("gap_no_trig", {triggered, fill}, {1'b0, 5'd0});
    feed(8'd51, 1'b0);
    feed(8'd52, 1'b0);
    check("gap_fill", {triggered, fill}, {1'b0, 5'd2});

    // Clamp and re-arm during readout
    post_count = 5'd20;
    do_arm();
    feed(8'd100, 1'b1);
    for (int a = 101; a <= 117; a++) feed(8'(a), 1'b0);
    check("clamp_done", done, 1'b1);
    check("clamp_fill", fill, 5'd16);
    check("clamp_trig_index", trig_index, 5'd0);
    for (int a = 100; a <= 102; a++) expect_entry(8'(a), 1'b0);
    rd_en = 1'b1;
    repeat (3) tick();
    arm = 1'b1;
    tick();
    arm   = 1'b0;
    rd_en = 1'b0;
    check("rearm_state", {done, fill, armed, triggered}, {1'b0, 5'd0, 1'b1, 1'b0});
    tick();
    tick();
    check("rearm_drain", 64'(exp_q.size()), 64'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
